uart_mmio: RTL and testbench
============================

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width of the data-memory bus.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1001_0000, word-aligned base of a 16-byte register window.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (min 4).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries (power of two).
REQ-005 SHALL have these ports:
  - clk  in  1  core clock; all state updates on rising edge.
  - rst  in  1  reset, asynchronous, active-low.
  - MemRead  in  1  core data-bus read strobe.
  - MemWrite  in  1  core data-bus write strobe.
  - RWAddress  in  DATA_WIDTH  core data-bus address.
  - WriteData  in  DATA_WIDTH  core store data.
  - RxD  in  1  asynchronous serial input, idle high.
  - ReadData  out  DATA_WIDTH  register read data, muxed with RAM by the top level.
  - Sel  out  1  high when RWAddress[31:4] == BASE_ADDR[31:4].
  - TxD  out  1  serial output, idle high.

Function
REQ-006 SHALL decode these offsets:
  - 0x0 TXDATA: write-only; pushes WriteData[7:0].
  - 0x4 STATUS: read bit0 tx_busy, bit1 fifo_full, bit2 fifo_empty, bit3 rx_valid, bit4 tx_overflow, bit5 frame_err, bit6 rx_overrun, others 0; any write clears bits 4-6.
  - 0x8 RXDATA: read {24'h0, rx_byte}.
  - 0xC: reads 0; writes ignored.
REQ-007 ReadData SHALL be combinational from RWAddress and register state, valid in the same cycle, and 0 when Sel=0 or MemRead=0.
REQ-008 Register writes and read side effects SHALL take effect only on a rising edge with Sel=1 and the matching strobe.
REQ-009 A TXDATA write SHALL push one byte into the TX FIFO.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and tx_overflow is set (sticky).
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
REQ-010 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter 0..FIFO_DEPTH driving full and empty.
REQ-011 The TX FSM SHALL have states T_IDLE, T_START, T_DATA, T_STOP:
  - T_IDLE with FIFO non-empty: pop at the next edge and enter T_START.
  - T_START: TxD=0 for CLKS_PER_BIT cycles.
  - T_DATA: 8 bits LSB-first, each CLKS_PER_BIT cycles.
  - T_STOP: TxD=1 for CLKS_PER_BIT cycles, then T_IDLE.
REQ-012 tx_busy SHALL be 1 in every state other than T_IDLE.
REQ-013 The start bit SHALL begin 2 cycles after the TXDATA write edge when the FSM is idle and the FIFO is empty.
REQ-014 RxD SHALL pass through a 2-flop synchronizer before any use.
REQ-015 The RX FSM SHALL have states R_IDLE, R_START, R_DATA, R_STOP:
  - R_IDLE: a low on synchronized RxD enters R_START.
  - R_START: at CLKS_PER_BIT/2 cycles, if the line is high return to R_IDLE (glitch), else enter R_DATA.
  - R_DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB-first.
  - R_STOP: sample after CLKS_PER_BIT cycles.
REQ-016 In R_STOP, a high sample SHALL load rx_byte and set rx_valid.
  - If rx_valid was already 1, rx_overrun is also set and the new byte overwrites.
  - A low stop sample sets frame_err, leaves rx_byte unchanged, and returns to R_IDLE.
REQ-017 A RXDATA read SHALL clear rx_valid at that edge.
  - If a new byte completes on the same edge, the new byte is loaded, rx_valid stays 1, and rx_overrun is not set.
REQ-018 TX and RX SHALL operate independently and concurrently.

Reset
REQ-019 While rst=0, asynchronously and immediately:
  - TxD=1.
  - FIFO empty, pointers 0.
  - Both FSMs idle; baud and bit counters 0.
  - rx_byte=0; all status flags 0 except fifo_empty=1.
  - Synchronizer flops = 1.
REQ-020 Reset asserted mid-frame SHALL abort the frame and force TxD=1; no partial byte is loaded on RX.
REQ-021 After rst deasserts, the first operation SHALL be accepted on the next rising edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-022 Reset then read STATUS -> ReadData=32'h4 and TxD=1.
REQ-023 Write 32'hA5 to TXDATA -> TxD low at cycles 2..5, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high, tx_busy=1 throughout and 0 afterwards.
REQ-024 Write 6 bytes back-to-back -> byte 1 popped, bytes 2-5 fill the FIFO (full=1), byte 6 dropped with tx_overflow=1, 5 frames transmitted; a STATUS write clears overflow.
REQ-025 Drive frame 0x3C on RxD -> rx_valid=1 and RXDATA=32'h3C; reading RXDATA -> rx_valid=0. A second frame without an intervening read -> rx_overrun=1.
REQ-026 Drive a frame with stop bit 0 -> frame_err=1 and rx_valid=0. A 1-cycle low glitch on RxD -> no state change.
REQ-027 Assert rst mid-TX-frame -> TxD=1 immediately and STATUS=32'h4 after release.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with a TX FIFO and a single-byte RX holding register.
// Register window: 0x0 TXDATA (push), 0x4 STATUS, 0x8 RXDATA, 0xC reserved.
module uart_mmio #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000,
    parameter int                    CLKS_PER_BIT = 434,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] RWAddress,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RxD,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Sel,
    output logic                  TxD
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // ---------------- bus decode ----------------
    logic [3:0] offset;
    logic       wr_txdata, wr_status, rd_rxdata;
    logic       unused_wdata;

    assign Sel          = (RWAddress[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4]);
    assign offset       = RWAddress[3:0];
    assign wr_txdata    = Sel && MemWrite && (offset == 4'h0);
    assign wr_status    = Sel && MemWrite && (offset == 4'h4);
    assign rd_rxdata    = Sel && MemRead  && (offset == 4'h8);
    assign unused_wdata = ^WriteData[DATA_WIDTH-1:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full, fifo_empty, tx_pop, push_ok, push_drop;
    tx_state_t        tx_state, tx_next;

    assign fifo_full  = (fifo_count == FIFO_FULL);
    assign fifo_empty = (fifo_count == '0);
    assign tx_pop     = (tx_state == T_IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = wr_txdata && (!fifo_full || tx_pop);
    assign push_drop  = wr_txdata && fifo_full && !tx_pop;

    // FIFO storage write port.
    // NOTE: the data array has no reset; only pointers and count need a known value,
    // and leaving the array unreset lets it map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= WriteData[7:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two).
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (tx_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, tx_pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- TX engine ----------------
    logic [BAUD_W-1:0] tx_baud;
    logic [2:0]        tx_bit;
    logic [7:0]        tx_shift;
    logic              tx_done, txd_q;

    assign tx_done = (tx_baud == BAUD_LAST);
    assign TxD     = txd_q;

    // TX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= T_IDLE;
        else      tx_state <= tx_next;
    end

    // TX next-state logic.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (!fifo_empty) tx_next = T_START;
            T_START: if (tx_done) tx_next = T_DATA;
            T_DATA:  if (tx_done && tx_bit == 3'd7) tx_next = T_STOP;
            T_STOP:  if (tx_done) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    // TX baud/bit counters, shift register and registered line driver (one cycle behind state).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            case (tx_state)
                T_START: txd_q <= 1'b0;
                T_DATA:  txd_q <= tx_shift[0];
                default: txd_q <= 1'b1;
            endcase
            if (tx_state == T_IDLE) begin
                tx_baud <= '0;
                tx_bit  <= '0;
                if (tx_pop) tx_shift <= fifo_mem[rd_ptr];
            end else if (tx_done) begin
                tx_baud <= '0;
                if (tx_state == T_DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_baud <= tx_baud + BAUD_W'(1);
            end
        end
    end

    // ---------------- RX engine ----------------
    logic              rx_sync1, rx_line;
    rx_state_t         rx_state, rx_next;
    logic [BAUD_W-1:0] rx_baud;
    logic [2:0]        rx_bit;
    logic [7:0]        rx_shift;
    logic              rx_full_bit, rx_half_bit, rx_done_ok, rx_done_bad;

    assign rx_full_bit = (rx_baud == BAUD_LAST);
    assign rx_half_bit = (rx_baud == BAUD_HALF);
    assign rx_done_ok  = (rx_state == R_STOP) && rx_full_bit && rx_line;
    assign rx_done_bad = (rx_state == R_STOP) && rx_full_bit && !rx_line;

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync1 <= 1'b1;
            rx_line  <= 1'b1;
        end else begin
            rx_sync1 <= RxD;
            rx_line  <= rx_sync1;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= R_IDLE;
        else      rx_state <= rx_next;
    end

    // RX next-state logic; a start bit that is high again at mid-bit is a glitch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (!rx_line) rx_next = R_START;
            R_START: if (rx_half_bit) rx_next = rx_line ? R_IDLE : R_DATA;
            R_DATA:  if (rx_full_bit && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP:  if (rx_full_bit) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // RX baud/bit counters and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    rx_baud <= '0;
                    rx_bit  <= '0;
                end
                R_START: rx_baud <= rx_half_bit ? '0 : rx_baud + BAUD_W'(1);
                R_DATA: begin
                    if (rx_full_bit) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_line, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_baud <= rx_baud + BAUD_W'(1);
                    end
                end
                default: rx_baud <= rx_full_bit ? '0 : rx_baud + BAUD_W'(1);
            endcase
        end
    end

    // ---------------- status / data registers ----------------
    logic [7:0] rx_byte;
    logic       rx_valid, rx_overrun, frame_err, tx_overflow;
    logic [6:0] status;

    assign status = {rx_overrun, frame_err, tx_overflow, rx_valid,
                     fifo_empty, fifo_full, (tx_state != T_IDLE)};

    // Sticky flags: a STATUS write clears them, but an event on the same edge wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (wr_status) begin
                rx_overrun  <= 1'b0;
                frame_err   <= 1'b0;
                tx_overflow <= 1'b0;
            end
            if (push_drop)   tx_overflow <= 1'b1;
            if (rx_done_bad) frame_err   <= 1'b1;
            if (rx_done_ok) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_rxdata) rx_overrun <= 1'b1;
            end else if (rd_rxdata) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Combinational read mux; zero unless this window is selected and read.
    always_comb begin
        ReadData = '0;
        if (Sel && MemRead) begin
            case (offset)
                4'h4:    ReadData = DATA_WIDTH'(status);
                4'h8:    ReadData = DATA_WIDTH'(rx_byte);
                default: ReadData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_uart_mmio;
    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_RX = BASE + 32'h8;
    localparam logic [31:0] A_NC = BASE + 32'hC;

    logic        clk = 1'b0, rst = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, RxD = 1'b1;
    logic [31:0] RWAddress = '0, WriteData = '0;
    logic [31:0] ReadData;
    logic        Sel, TxD;

    int total = 0;
    int bad   = 0;
    logic [7:0] tx_q [$];

    uart_mmio #(
        .DATA_WIDTH(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .RWAddress(RWAddress), .WriteData(WriteData), .RxD(RxD),
        .ReadData(ReadData), .Sel(Sel), .TxD(TxD)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus write, consuming exactly one rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        RWAddress = a; WriteData = d; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    // Read strobed across one rising edge (carries read side effects).
    task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        RWAddress = a; MemRead = 1'b1;
        #1 check(name, ReadData, exp);
        @(negedge clk);
        MemRead = 1'b0;
    endtask

    // Combinational look at a register without crossing an edge.
    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        RWAddress = a; MemRead = 1'b1;
        #1 check(name, ReadData, exp);
        MemRead = 1'b0;
    endtask

    // Drive one 8N1 frame on RxD with a chosen stop-bit level.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop_bit;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
    endtask

    // Poll STATUS until the transmitter is idle and the FIFO empty, within a cycle budget.
    task automatic wait_tx_idle(input string name, input int budget);
        int  n = 0;
        logic done = 1'b0;
        while (!done && n < budget) begin
            RWAddress = A_ST; MemRead = 1'b1;
            #1;
            if (ReadData[0] == 1'b0 && ReadData[2] == 1'b1) done = 1'b1;
            MemRead = 1'b0;
            if (!done) begin
                @(negedge clk);
                n++;
            end
        end
        check(name, {31'b0, done}, 32'h1);
    endtask

    // Expected TxD after edge n, where edge 0 is the TXDATA write into an idle, empty UART.
    function automatic logic exp_txd(input int n, input logic [7:0] b);
        if (n < 2)  return 1'b1;
        if (n <= 5) return 1'b0;
        if (n <= 37) return b[(n - 6) / 4];
        return 1'b1;
    endfunction

    // Independent serial decoder: samples mid-bit and collects correctly framed bytes.
    initial begin
        logic [7:0] mon_b;
        forever begin
            @(negedge clk);
            if (rst && TxD == 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = TxD;
                end
                repeat (CPB) @(negedge clk);
                if (TxD) tx_q.push_back(mon_b);
            end
        end
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_sel;
    } vec_t;

    vec_t vecs [9];
    logic [7:0] exp_bytes [6];

    initial begin
        vecs[0] = '{"status_read",    1'b1, 1'b0, A_ST,               32'h0,  32'h4, 1'b1};
        vecs[1] = '{"txdata_read",    1'b1, 1'b0, A_TX,               32'h0,  32'h0, 1'b1};
        vecs[2] = '{"rxdata_read",    1'b1, 1'b0, A_RX,               32'h0,  32'h0, 1'b1};
        vecs[3] = '{"reserved_read",  1'b1, 1'b0, A_NC,               32'h0,  32'h0, 1'b1};
        vecs[4] = '{"status_no_strb", 1'b0, 1'b0, A_ST,               32'h0,  32'h0, 1'b1};
        vecs[5] = '{"above_window",   1'b1, 1'b0, BASE + 32'h14,      32'h0,  32'h0, 1'b0};
        vecs[6] = '{"below_window",   1'b1, 1'b0, BASE - 32'h4,       32'h0,  32'h0, 1'b0};
        vecs[7] = '{"reserved_write", 1'b0, 1'b1, A_NC,               32'hFF, 32'h0, 1'b1};
        vecs[8] = '{"status_after",   1'b1, 1'b0, A_ST,               32'h0,  32'h4, 1'b1};
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};

        // Reset state, observed while reset is held.
        repeat (2) @(negedge clk);
        #1 check("reset_txd", {31'b0, TxD}, 32'h1);
        peek("reset_status", A_ST, 32'h4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven decode and read-mux checks.
        for (int i = 0; i < 9; i++) begin
            RWAddress = vecs[i].addr; WriteData = vecs[i].wdata;
            MemRead = vecs[i].rd; MemWrite = vecs[i].wr;
            #1;
            check({vecs[i].name, "_data"}, ReadData, vecs[i].exp_rdata);
            check({vecs[i].name, "_sel"}, {31'b0, Sel}, {31'b0, vecs[i].exp_sel});
            @(negedge clk);
            MemRead = 1'b0; MemWrite = 1'b0;
        end

        // Single byte 0xA5: cycle-exact line waveform and busy flag.
        tx_q.delete();
        bus_write(A_TX, 32'hA5);
        RWAddress = A_ST; MemRead = 1'b1;
        for (int n = 0; n <= 45; n++) begin
            #1;
            check($sformatf("a5_txd_n%0d", n), {31'b0, TxD}, {31'b0, exp_txd(n, 8'hA5)});
            check($sformatf("a5_busy_n%0d", n), {31'b0, ReadData[0]},
                  {31'b0, (n >= 1 && n <= 40)});
            @(negedge clk);
        end
        MemRead = 1'b0;
        check("a5_frames", tx_q.size(), 32'h1);
        if (tx_q.size() > 0) check("a5_byte", {24'h0, tx_q[0]}, 32'hA5);
        peek("a5_status_idle", A_ST, 32'h4);

        // Six back-to-back writes: one popped, four fill the FIFO, the sixth is dropped.
        tx_q.delete();
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        bus_write(A_TX, 32'h33);
        bus_write(A_TX, 32'h44);
        bus_write(A_TX, 32'h55);
        bus_write(A_TX, 32'h66);
        peek("burst_status_full_ovf", A_ST, 32'h13);
        // The second pop happens on edge 42 of the burst; a push into the full FIFO there is kept.
        repeat (36) @(negedge clk);
        bus_write(A_TX, 32'h77);
        peek("push_on_pop_still_full", A_ST, 32'h13);
        wait_tx_idle("burst_drain", 600);
        check("burst_frames", tx_q.size(), 32'h6);
        for (int i = 0; i < 6; i++)
            if (i < tx_q.size())
                check($sformatf("burst_byte%0d", i), {24'h0, tx_q[i]}, {24'h0, exp_bytes[i]});
        peek("burst_ovf_sticky", A_ST, 32'h14);
        bus_write(A_ST, 32'h0);
        peek("ovf_cleared", A_ST, 32'h4);

        // Receive 0x3C while transmitting 0x96.
        tx_q.delete();
        fork
            send_rx(8'h3C, 1'b1);
            bus_write(A_TX, 32'h96);
        join
        wait_tx_idle("concurrent_tx_idle", 100);
        repeat (2) @(negedge clk);
        peek("rx_valid_status", A_ST, 32'h0C);
        bus_read("rx_data_3c", A_RX, 32'h3C);
        peek("rx_valid_cleared", A_ST, 32'h04);
        check("concurrent_tx_frames", tx_q.size(), 32'h1);
        if (tx_q.size() > 0) check("concurrent_tx_byte", {24'h0, tx_q[0]}, 32'h96);

        // Overrun: two frames with no read in between.
        send_rx(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        send_rx(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        peek("overrun_status", A_ST, 32'h4C);
        bus_read("overrun_data", A_RX, 32'hC3);
        peek("overrun_after_read", A_ST, 32'h44);
        bus_write(A_ST, 32'h0);
        peek("overrun_cleared", A_ST, 32'h04);

        // Bad stop bit: frame error, byte register untouched.
        send_rx(8'h99, 1'b0);
        repeat (8) @(negedge clk);
        peek("frame_err_status", A_ST, 32'h24);
        peek("frame_err_data_kept", A_RX, 32'hC3);
        bus_write(A_ST, 32'h0);
        peek("frame_err_cleared", A_ST, 32'h04);

        // One-cycle low glitch on the line.
        RxD = 1'b0;
        @(negedge clk);
        RxD = 1'b1;
        repeat (10) @(negedge clk);
        peek("glitch_status", A_ST, 32'h04);
        peek("glitch_data", A_RX, 32'hC3);

        // RXDATA read on the same edge a new byte completes.
        send_rx(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        peek("pre_coincide_status", A_ST, 32'h0C);
        send_rx(8'hA3, 1'b1);
        bus_read("coincide_old_data", A_RX, 32'h5A);
        peek("coincide_status", A_ST, 32'h0C);
        bus_read("coincide_new_data", A_RX, 32'hA3);
        peek("coincide_drained", A_ST, 32'h04);

        // Reset in the middle of a transmitted start bit.
        bus_write(A_TX, 32'h55);
        repeat (3) @(negedge clk);
        #1 check("pre_reset_start_low", {31'b0, TxD}, 32'h0);
        rst = 1'b0;
        #1 check("reset_forces_txd", {31'b0, TxD}, 32'h1);
        peek("status_in_reset", A_ST, 32'h4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        peek("status_after_reset", A_ST, 32'h4);
        peek("rxdata_after_reset", A_RX, 32'h0);
        repeat (50) @(negedge clk);
        #1 check("txd_idle_after_reset", {31'b0, TxD}, 32'h1);
        peek("status_quiet_after_reset", A_ST, 32'h4);

        // Transmitter works again after the reset.
        tx_q.delete();
        bus_write(A_TX, 32'hF0);
        wait_tx_idle("post_reset_tx", 100);
        check("post_reset_frames", tx_q.size(), 32'h1);
        if (tx_q.size() > 0) check("post_reset_byte", {24'h0, tx_q[0]}, 32'hF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
